scan_div_mux: RTL and testbench

- Parametrised digit-scan timing generator for the multiplexed 7-segment display path.
- Divides the 27 MHz board clock into a square-wave scan clock.
- Rotates a one-hot select across N_CH digit-driver BJTs, with optional blanking (dead time) between digits to suppress ghosting.
- The half-period is reloadable at runtime; sits between the clock source and the display driver/segment mux.

---
 rtl/scan_pkg.sv | 27 ++
 rtl/div_counter.sv | 34 +++
 rtl/scan_div_mux.sv | 91 +++++++++
 tb/tb_scan_div_mux.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and helpers for the digit-scan timing generator.
package scan_pkg;

    typedef enum logic [0:0] {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } sel_state_t;

    localparam int unsigned MAX_CH = 16;

    // One-hot select for channel idx out of n; all-zero for an out-of-range index.
    function automatic logic [MAX_CH-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_CH-1:0] v;
        v = '0;
        if (idx < n && idx < MAX_CH) begin
            v = MAX_CH'(1) << idx[3:0];
        end
        return v;
    endfunction

    // Default half-period in clk cycles for a given input/scan frequency pair.
    function automatic longint unsigned half_period_of(input longint unsigned clk_freq,
                                                       input longint unsigned scan_freq);
        return clk_freq / (64'd2 * scan_freq);
    endfunction

endpackage

// File: rtl/div_counter.sv
// Reloadable half-period counter; terminal marks the enabled cycle that ends a half-period.
module div_counter #(
    parameter int unsigned      CNT_W    = 25,
    parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(13500)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             terminal
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] half_period;
    logic             at_last;

    // half_period is never zero, so the subtraction cannot wrap.
    assign at_last  = (count == half_period - CNT_W'(1));
    assign terminal = en && !load && at_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            half_period <= DEF_HALF;
        end else if (load) begin
            half_period <= (load_val == '0) ? CNT_W'(1) : load_val;
            count       <= '0;
        end else if (en) begin
            count <= at_last ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/scan_div_mux.sv
// Scan clock divider with one-hot digit rotation and optional dead time between digits.
module scan_div_mux
    import scan_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 27_000_000,
    parameter int unsigned SCAN_FREQ   = 1_000,
    parameter int unsigned N_CH        = 2,
    parameter int unsigned CNT_W       = 25,
    parameter int unsigned DEAD_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    div_load,
    input  logic [CNT_W-1:0]        div_val,
    output logic                    clk_out,
    output logic                    tick,
    output logic [$clog2(N_CH)-1:0] ch_idx,
    output logic [N_CH-1:0]         sel
);

    localparam int unsigned     IDX_W      = $clog2(N_CH);
    localparam longint unsigned DEF_HALF   = half_period_of(64'(CLK_FREQ), 64'(SCAN_FREQ));
    localparam longint unsigned CNT_MAX    = (64'd1 << CNT_W) - 64'd1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CH - 1);
    localparam logic [7:0]      BLANK_LAST = 8'((DEAD_CYCLES == 0) ? 0 : DEAD_CYCLES - 1);

    // Elaboration-time parameter sanity.
    if (N_CH < 2 || N_CH > 16) begin : g_bad_nch
        $error("scan_div_mux: N_CH must be in 2..16");
    end
    if (DEAD_CYCLES > 255) begin : g_bad_dead
        $error("scan_div_mux: DEAD_CYCLES must be in 0..255");
    end
    if (DEF_HALF == 0 || DEF_HALF > CNT_MAX) begin : g_bad_half
        $error("scan_div_mux: default half-period does not fit in CNT_W");
    end

    logic             terminal;
    logic [IDX_W-1:0] next_idx;
    logic [7:0]       blank_cnt;
    sel_state_t       state;

    div_counter #(
        .CNT_W   (CNT_W),
        .DEF_HALF(CNT_W'(DEF_HALF))
    ) u_div_counter (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (div_load),
        .load_val(div_val),
        .terminal(terminal)
    );

    assign next_idx = (ch_idx == LAST_IDX) ? '0 : ch_idx + IDX_W'(1);

    // Toggle/advance on terminal; blanking window counts only enabled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_out   <= 1'b0;
            tick      <= 1'b0;
            ch_idx    <= '0;
            sel       <= N_CH'(1);
            state     <= SHOW;
            blank_cnt <= '0;
        end else begin
            tick <= terminal;
            if (terminal) begin
                clk_out   <= ~clk_out;
                ch_idx    <= next_idx;
                blank_cnt <= '0;
                if (DEAD_CYCLES > 0) begin
                    state <= BLANK;
                    sel   <= '0;
                end else begin
                    state <= SHOW;
                    sel   <= N_CH'(onehot(32'(next_idx), N_CH));
                end
            end else if (en && state == BLANK) begin
                if (blank_cnt == BLANK_LAST) begin
                    state <= SHOW;
                    sel   <= N_CH'(onehot(32'(ch_idx), N_CH));
                end else begin
                    blank_cnt <= blank_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_div_mux.sv
// Scoreboard bench for scan_div_mux: directed phases plus random traffic against a cycle model.
module tb_scan_div_mux;

    localparam int unsigned CLK_FREQ  = 20;
    localparam int unsigned SCAN_FREQ = 2;
    localparam int unsigned N_CH      = 4;
    localparam int unsigned CNT_W     = 25;
    localparam int unsigned DEAD      = 2;
    localparam int unsigned DEF_HALF  = CLK_FREQ / (2 * SCAN_FREQ);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             div_load = 1'b0;
    logic [CNT_W-1:0] div_val = '0;
    logic             clk_out;
    logic             tick;
    logic [1:0]       ch_idx;
    logic [N_CH-1:0]  sel;

    always #5 clk = ~clk;

    scan_div_mux #(
        .CLK_FREQ   (CLK_FREQ),
        .SCAN_FREQ  (SCAN_FREQ),
        .N_CH       (N_CH),
        .CNT_W      (CNT_W),
        .DEAD_CYCLES(DEAD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_load(div_load),
        .div_val (div_val),
        .clk_out (clk_out),
        .tick    (tick),
        .ch_idx  (ch_idx),
        .sel     (sel)
    );

    typedef struct packed {
        logic            clk_out;
        logic            tick;
        logic [1:0]      ch_idx;
        logic [N_CH-1:0] sel;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   printed = 0;

    // Reference model: half-period counter, channel number, and remaining dead cycles.
    int m_count, m_half, m_idx, m_blank;
    bit m_clk, m_tick;

    function automatic obs_t model_out();
        obs_t o;
        o.clk_out = m_clk;
        o.tick    = m_tick;
        o.ch_idx  = 2'(m_idx);
        o.sel     = (m_blank > 0) ? '0 : N_CH'(1 << m_idx);
        return o;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit l, input int v);
        if (r) begin
            m_count = 0; m_half = DEF_HALF; m_clk = 0; m_tick = 0; m_idx = 0; m_blank = 0;
        end else begin
            m_tick = 0;
            if (l) begin
                m_half  = (v == 0) ? 1 : v;
                m_count = 0;
                if (e && m_blank > 0) m_blank--;
            end else if (e) begin
                if (m_blank > 0) m_blank--;
                if (m_count == m_half - 1) begin
                    m_count = 0;
                    m_clk   = !m_clk;
                    m_tick  = 1;
                    m_idx   = (m_idx + 1) % N_CH;
                    m_blank = DEAD;
                end else begin
                    m_count++;
                end
            end
        end
    endtask

    task automatic fail_line(input string name, input string got, input string want);
        failures++;
        if (printed < 40) begin
            $display("FAIL %s got=%s expected=%s t=%0t", name, got, want, $time);
            printed++;
        end
    endtask

    // One clock of stimulus; expectation for the following edge goes to the scoreboard.
    task automatic step(input bit r, input bit e, input bit l, input int v);
        @(negedge clk);
        rst = r; en = e; div_load = l; div_val = CNT_W'(v);
        model_step(r, e, l, v);
        exp_q.push_back(model_out());
    endtask

    task automatic expect_reached(input string name, input bit ok);
        checks++;
        if (!ok) fail_line(name, "not reached", "reached");
    endtask

    // Monitor: compares every post-edge observation against the queued expectation.
    initial begin
        obs_t got, want;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = '{clk_out: clk_out, tick: tick, ch_idx: ch_idx, sel: sel};
                checks++;
                if (got !== want)
                    fail_line("outputs", $sformatf("clk_out=%b tick=%b ch_idx=%0d sel=%b",
                              got.clk_out, got.tick, got.ch_idx, got.sel),
                              $sformatf("clk_out=%b tick=%b ch_idx=%0d sel=%b",
                              want.clk_out, want.tick, want.ch_idx, want.sel));
                checks++;
                if ($countones(sel) > 1)
                    fail_line("sel_onehot", $sformatf("%b", sel), "at most one bit");
                checks++;
                if (ch_idx >= 2'(N_CH - 1) + 2'd1 && N_CH < 4)
                    fail_line("ch_idx_range", $sformatf("%0d", ch_idx), "< N_CH");
            end
        end
    end

    initial begin
        int w;
        step(1, 0, 0, 0);
        step(1, 1, 1, 9);

        // Free run: several toggles and a full channel wrap with dead time.
        for (int i = 0; i < 45; i++) step(0, 1, 0, 0);

        // Reload to 3 mid-count, then reload with zero (toggle every cycle).
        for (w = 0; w < 20 && m_count != 2; w++) step(0, 1, 0, 0);
        expect_reached("mid_count_for_load3", m_count == 2);
        step(0, 1, 1, 3);
        for (int i = 0; i < 14; i++) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);

        // Load coinciding with a terminal count suppresses the toggle.
        step(0, 1, 1, 5);
        for (w = 0; w < 20 && m_count != m_half - 1; w++) step(0, 1, 0, 0);
        expect_reached("terminal_for_load", m_count == m_half - 1);
        step(0, 1, 1, 5);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0);

        // Pause mid-period and mid-blank, then resume.
        for (w = 0; w < 20 && !(m_blank == DEAD && m_tick); w++) step(0, 1, 0, 0);
        expect_reached("advance_for_pause", m_blank == DEAD);
        step(0, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0);

        // Reset while blanking on channel 2.
        for (w = 0; w < 60 && !(m_idx == 2 && m_blank > 0); w++) step(0, 1, 0, 0);
        expect_reached("blank_on_ch2", m_idx == 2 && m_blank > 0);
        step(1, 1, 1, 7);
        for (int i = 0; i < 25; i++) step(0, 1, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 2500; i++) begin
            bit r, e, l;
            r = ($urandom_range(0, 399) == 0);
            e = ($urandom_range(0, 99) < 85);
            l = ($urandom_range(0, 99) < 3);
            step(r, e, l, int'($urandom_range(0, 8)));
        end

        for (w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0)
            fail_line("scoreboard_drain", $sformatf("%0d pending", exp_q.size()), "0 pending");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
